// File: rtl/jk_mod_counter_if.sv
// Purpose: control and status bundle for the JK modulo counter.
//   en, up_dn, load, d_in : counter controls, driven by the master
//   q, tc, wrap           : count value and terminal-count/wrap status, driven by the counter
`timescale 1ns/1ps
interface jk_mod_counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;

    modport master (
        output en, up_dn, load, d_in,
        input  q, tc, wrap
    );

    modport slave (
        input  en, up_dn, load, d_in,
        output q, tc, wrap
    );
endinterface

// File: rtl/jk_mod_counter.sv
// Purpose: synchronous modulo-MODULUS up/down counter. Each count bit is a JK cell
//   whose J/K inputs are decoded from the desired next count.
// Ports:
//   clk  : clock, rising-edge active
//   rst  : asynchronous active-low reset (clears count and wrap)
//   bus  : jk_mod_counter_if.slave -- en/up_dn/load/d_in in, q/tc/wrap out
//          (tc is combinational, q and wrap are registered)
`timescale 1ns/1ps
module jk_mod_counter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    jk_mod_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic [WIDTH-1:0] w_nxt;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic             w_wrap_nxt;
    logic             w_at_max;
    logic             w_at_zero;

    // Next-count selection: load (clamped) > count up/down > hold.
    always_comb begin
        w_nxt      = r_q;
        w_wrap_nxt = 1'b0;
        w_at_max   = (r_q == MAX_VAL);
        w_at_zero  = (r_q == '0);
        if (bus.load) begin
            w_nxt = (bus.d_in > MAX_VAL) ? MAX_VAL : bus.d_in;
        end else if (bus.en) begin
            if (bus.up_dn) begin
                if (w_at_max) begin
                    w_nxt      = '0;
                    w_wrap_nxt = 1'b1;
                end else begin
                    w_nxt = r_q + WIDTH'(1);
                end
            end else begin
                if (w_at_zero) begin
                    w_nxt      = MAX_VAL;
                    w_wrap_nxt = 1'b1;
                end else begin
                    w_nxt = r_q - WIDTH'(1);
                end
            end
        end
        // Set a cell that must rise, clear a cell that must fall, otherwise hold.
        w_j = ~r_q & w_nxt;
        w_k = r_q & ~w_nxt;
    end

    // Row of JK cells; the only path that updates the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                case ({w_j[i], w_k[i]})
                    2'b01:   r_q[i] <= 1'b0;
                    2'b10:   r_q[i] <= 1'b1;
                    2'b11:   r_q[i] <= ~r_q[i];
                    default: r_q[i] <= r_q[i];
                endcase
            end
        end
    end

    // One-cycle pulse following a wrap edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_wrap_nxt;
        end
    end

    assign bus.q    = r_q;
    assign bus.wrap = r_wrap;
    // Terminal count: the next enabled, non-load edge will wrap.
    assign bus.tc   = bus.en & ~bus.load &
                      ((bus.up_dn & w_at_max) | (~bus.up_dn & w_at_zero));
endmodule
